// File: rtl/thumb_pkg.sv
`default_nettype none
// ============================================================================
// thumb_pkg: shared geometry and capture-state type for the thumbnail upscaler
// Revision: 1.0
// ============================================================================
package thumb_pkg;
    localparam int SRC_W     = 32;
    localparam int SRC_H     = 32;
    localparam int H_SCALE   = 20;
    localparam int V_SCALE   = 15;
    localparam int DST_W     = SRC_W * H_SCALE;
    localparam int DST_H     = SRC_H * V_SCALE;
    localparam int PIX_TOTAL = SRC_W * SRC_H;

    // wcnt must hold PIX_TOTAL itself, hence the extra bit
    localparam int WCNT_W = $clog2(PIX_TOTAL) + 1;
    localparam int RAM_AW = $clog2(PIX_TOTAL) + 1;
    localparam int XW     = $clog2(SRC_W);
    localparam int YW     = $clog2(SRC_H);
    localparam int HW     = $clog2(H_SCALE);
    localparam int VW     = $clog2(V_SCALE);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } cap_state_t;
endpackage
`default_nettype wire

// File: rtl/thumb_ram.sv
`default_nettype none
// ============================================================================
// thumb_ram: simple dual-port RAM, one write port, one registered read port
// Revision: 1.0
// ============================================================================
module thumb_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/thumbnail_upscale.sv
`default_nettype none
// ============================================================================
// thumbnail_upscale: ping-pong capture of a 32x32 thumbnail, served to a
// 640x480 raster by nearest-neighbour replication.
// Revision: 1.0
// ============================================================================
module thumbnail_upscale
    import thumb_pkg::*;
#(
    parameter logic [7:0] BLANK_PIX = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iWr,
    input  logic [7:0] iPix,
    input  logic       iFrameDone,
    input  logic       iFrameStart,
    input  logic       iRead,
    output logic [7:0] oPix,
    output logic       oPixValid,
    output logic       oReady,
    output logic       oErr
);
    localparam logic [WCNT_W-1:0] PIX_END = WCNT_W'(PIX_TOTAL);
    localparam logic [HW-1:0]     H_LAST  = HW'(H_SCALE - 1);
    localparam logic [XW-1:0]     X_LAST  = XW'(SRC_W - 1);
    localparam logic [VW-1:0]     V_LAST  = VW'(V_SCALE - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(SRC_H - 1);

    cap_state_t        state_q, state_d;
    logic              wbank_q, wbank_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [HW-1:0]     h_q, h_d, h_base;
    logic [XW-1:0]     x_q, x_d, x_base;
    logic [VW-1:0]     v_q, v_d, v_base;
    logic [YW-1:0]     y_q, y_d, y_base;
    logic              pix_valid_q, pix_valid_d;
    logic              rd_ready_q, rd_ready_d;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;
    logic [7:0]        ram_rdata;

    // Capture side: the count tested at iFrameDone includes a same-cycle write
    always_comb begin
        state_d = state_q;
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        ready_d = ready_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        case (state_q)
            FILL: begin
                if (iWr) begin
                    if (wcnt_q != PIX_END) begin
                        ram_we = 1'b1;
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (iFrameDone) begin
                    if (wcnt_d == PIX_END) begin
                        if (iFrameStart) begin
                            wbank_d = ~wbank_q;
                            wcnt_d  = '0;
                            ready_d = 1'b1;
                        end else begin
                            state_d = PEND;
                        end
                    end else begin
                        err_d  = 1'b1;
                        wcnt_d = '0;
                    end
                end
            end
            PEND: begin
                if (iWr) begin
                    err_d = 1'b1;
                end
                if (iFrameStart) begin
                    wbank_d = ~wbank_q;
                    wcnt_d  = '0;
                    ready_d = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign ram_waddr = {wbank_q, wcnt_q[WCNT_W-2:0]};

    // Display side: a frame start clears the counters before any same-cycle read
    always_comb begin
        h_base = iFrameStart ? '0 : h_q;
        x_base = iFrameStart ? '0 : x_q;
        v_base = iFrameStart ? '0 : v_q;
        y_base = iFrameStart ? '0 : y_q;
        h_d    = h_base;
        x_d    = x_base;
        v_d    = v_base;
        y_d    = y_base;
        if (iRead) begin
            if (h_base == H_LAST) begin
                h_d = '0;
                if (x_base == X_LAST) begin
                    x_d = '0;
                    if (v_base == V_LAST) begin
                        v_d = '0;
                        y_d = (y_base == Y_LAST) ? '0 : y_base + YW'(1);
                    end else begin
                        v_d = v_base + VW'(1);
                    end
                end else begin
                    x_d = x_base + XW'(1);
                end
            end else begin
                h_d = h_base + HW'(1);
            end
        end
        pix_valid_d = iRead;
        rd_ready_d  = iRead ? ready_d : rd_ready_q;
    end

    assign ram_raddr = {~wbank_d, y_base, x_base};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wbank_q     <= 1'b0;
            wcnt_q      <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            h_q         <= '0;
            x_q         <= '0;
            v_q         <= '0;
            y_q         <= '0;
            pix_valid_q <= 1'b0;
            rd_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbank_q     <= wbank_d;
            wcnt_q      <= wcnt_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            h_q         <= h_d;
            x_q         <= x_d;
            v_q         <= v_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            rd_ready_q  <= rd_ready_d;
        end
    end

    thumb_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (iPix),
        .re    (iRead),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign oPix      = rd_ready_q ? ram_rdata : BLANK_PIX;
    assign oPixValid = pix_valid_q;
    assign oReady    = ready_q;
    assign oErr      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_thumbnail_upscale.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_thumbnail_upscale: directed vectors and sequences for thumbnail_upscale
// Revision: 1.0
// ============================================================================
module tb_thumbnail_upscale;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iWr = 1'b0;
    logic [7:0] iPix = 8'h00;
    logic       iFrameDone = 1'b0;
    logic       iFrameStart = 1'b0;
    logic       iRead = 1'b0;
    logic [7:0] oPix;
    logic       oPixValid;
    logic       oReady;
    logic       oErr;

    always #5 clk = ~clk;

    thumbnail_upscale #(.BLANK_PIX(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iWr         (iWr),
        .iPix        (iPix),
        .iFrameDone  (iFrameDone),
        .iFrameStart (iFrameStart),
        .iRead       (iRead),
        .oPix        (oPix),
        .oPixValid   (oPixValid),
        .oReady      (oReady),
        .oErr        (oErr)
    );

    typedef struct {
        logic       wr;
        logic [7:0] pix;
        logic       done;
        logic       start;
        logic       rd;
        logic       exp_valid;
        logic [7:0] exp_pix;
        logic       exp_ready;
        logic       exp_err;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int rd_n = 0;

    // Image patterns: 0 = index, 1 = flat 0x55, 2 = index^0x3C, 3 = 3*index, 4 = index^0x5A
    function automatic logic [7:0] img_val(int img, int idx);
        int t;
        t = idx;
        case (img)
            0: return t[7:0];
            1: return 8'h55;
            2: return t[7:0] ^ 8'h3C;
            3: begin t = idx * 3; return t[7:0]; end
            4: return t[7:0] ^ 8'h5A;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int src_idx(int n);
        int dx, dy;
        dx = n % 640;
        dy = n / 640;
        return (dy / 15) * 32 + dx / 20;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] pix, input logic done,
                        input logic start, input logic rd);
        iWr = wr; iPix = pix; iFrameDone = done; iFrameStart = start; iRead = rd;
        @(posedge clk);
        #1;
        iWr = 1'b0; iPix = 8'h00; iFrameDone = 1'b0; iFrameStart = 1'b0; iRead = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int img);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk({name, " valid"}, oPixValid, 1);
        chk({name, " pix"}, oPix, img_val(img, src_idx(rd_n)));
        rd_n++;
    endtask

    task automatic write_img(input int img, input int n);
        for (int i = 0; i < n; i++) step(1'b1, img_val(img, i), 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        // wr pix done start rd | valid pix ready err
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset oPix", oPix, 0);
        chk("reset oPixValid", oPixValid, 0);
        chk("reset oReady", oReady, 0);
        chk("reset oErr", oErr, 0);

        // Reads with no thumbnail yet
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].wr, tbl[i].pix, tbl[i].done, tbl[i].start, tbl[i].rd);
            chk($sformatf("vec%0d valid", i), oPixValid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("vec%0d pix", i), oPix, tbl[i].exp_pix);
            chk($sformatf("vec%0d ready", i), oReady, tbl[i].exp_ready);
            chk($sformatf("vec%0d err", i), oErr, tbl[i].exp_err);
        end

        // Image A captured; invisible until the next frame start
        write_img(0, 1024);
        chk("A pre-done ready", oReady, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("A pend ready", oReady, 0);
        chk("A err", oErr, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("A pend blank", oPix, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        rd_n = 0;
        chk("A start+read pix", oPix, img_val(0, 0));
        chk("A start+read valid", oPixValid, 1);
        chk("A ready", oReady, 1);
        rd_n = 1;
        while (rd_n < 640 * 16) rd_chk("imgA", 0);

        // Ping-pong: B written mid-frame while A keeps displaying
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
            chk("pp A during B", oPix, img_val(0, src_idx(rd_n)));
            rd_n++;
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("pp A at done", oPix, img_val(0, src_idx(rd_n)));
        rd_n++;
        repeat (10) rd_chk("pp A after done", 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        rd_n = 0;
        repeat (700) rd_chk("pp B", 1);

        // Short stream is discarded, then a full one is accepted
        write_img(2, 1000);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("short err", oErr, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        rd_n = 0;
        repeat (40) rd_chk("short keeps B", 1);
        write_img(2, 1024);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        rd_n = 0;
        repeat (700) rd_chk("after short C", 2);
        chk("after short err sticky", oErr, 1);

        // Reset, then an overlong stream
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst2 err", oErr, 0);
        chk("rst2 ready", oReady, 0);
        write_img(3, 1024);
        chk("long err before extra", oErr, 0);
        repeat (6) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("long err", oErr, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("long pend ready", oReady, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        rd_n = 0;
        chk("long first pix", oPix, img_val(3, 0));
        chk("long ready", oReady, 1);
        rd_n = 1;
        repeat (700) rd_chk("long D", 3);

        // Done and start in the same cycle, with the last write and a read
        write_img(4, 1023);
        step(1'b1, img_val(4, 1023), 1'b1, 1'b1, 1'b1);
        rd_n = 0;
        chk("same-cycle swap pix", oPix, img_val(4, 0));
        chk("same-cycle ready", oReady, 1);
        rd_n = 1;
        repeat (100) rd_chk("same-cycle E", 4);

        // Asynchronous reset mid-capture and mid-frame
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
            rd_n++;
        end
        chk("pre-rst valid", oPixValid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst oPix", oPix, 0);
        chk("async rst valid", oPixValid, 0);
        chk("async rst ready", oReady, 0);
        chk("async rst err", oErr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            chk("post-rst blank", oPix, 0);
            chk("post-rst valid", oPixValid, 1);
            chk("post-rst ready", oReady, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
